// File: rtl/event_enc_pkg.sv
// Shared constants and helpers for the 16-source event encoder.
package event_enc_pkg;

  localparam int unsigned N    = 16;
  localparam int unsigned IDXW = 4;

  // Index to one-hot 16-bit mask.
  function automatic logic [N-1:0] onehot16(input logic [IDXW-1:0] idx);
    logic [N-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/rr_prio_enc16.sv
// Combinational round-robin priority encoder: first set bit of cand at or above ptr, wrapping mod 16.
module rr_prio_enc16
  import event_enc_pkg::*;
(
  input  logic [N-1:0]    cand,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  logic [N-1:0]    rot;
  logic [IDXW-1:0] off;

  // Rotate so ptr lands on bit 0, pick lowest set bit, then undo the rotation.
  always_comb begin
    rot = N'({cand, cand} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDXW'(i);
    end
    found = |cand;
    idx   = off + ptr;
  end

endmodule

// File: rtl/event_encoder16.sv
// Captures event pulses into a sticky pending register and serializes them as round-robin indices.
module event_encoder16
  import event_enc_pkg::*;
(
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            enable_i,
  input  logic            clear_i,
  input  logic [N-1:0]    event_i,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [N-1:0]    pending_o,
  output logic            drop_o,
  output logic [7:0]      drop_cnt_o
);

  localparam int unsigned CNTW    = 8;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [N-1:0]    pending_q;
  logic [IDXW-1:0] ptr_q;

  logic            accept;
  logic            load;
  logic [N-1:0]    ack_mask;
  logic [N-1:0]    armed;
  logic [N-1:0]    cand;
  logic [N-1:0]    pending_next;
  logic            drop_now;
  logic [IDXW-1:0] win_idx;
  logic            win_found;

  // The presented bit stays pending until acked, so selection only sees un-acked bits.
  always_comb begin
    accept       = valid_o & ready_i;
    load         = ~valid_o | accept;
    ack_mask     = accept ? onehot16(idx_o) : '0;
    armed        = event_i & {N{enable_i}};
    cand         = pending_q & ~ack_mask;
    pending_next = cand | armed;
    drop_now     = |(armed & cand);
  end

  rr_prio_enc16 u_prio (
    .cand  (cand),
    .ptr   (ptr_q),
    .idx   (win_idx),
    .found (win_found)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q  <= '0;
      ptr_q      <= '0;
      idx_o      <= '0;
      valid_o    <= 1'b0;
      drop_o     <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      pending_q  <= '0;
      ptr_q      <= '0;
      idx_o      <= '0;
      valid_o    <= 1'b0;
      drop_o     <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      pending_q <= pending_next;
      drop_o    <= drop_now;
      if (drop_now && (drop_cnt_o != CNT_MAX)) drop_cnt_o <= drop_cnt_o + CNTW'(1);
      if (accept) ptr_q <= idx_o + IDXW'(1);
      if (load) begin
        if (win_found) begin
          idx_o   <= win_idx;
          valid_o <= 1'b1;
        end else begin
          valid_o <= 1'b0;
        end
      end
    end
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_event_encoder16.sv
// Scoreboard bench for event_encoder16: directed stimulus queues expected indices, a monitor checks each handshake.
module tb_event_encoder16;
  import event_enc_pkg::*;

  logic            clk;
  logic            rstn;
  logic            enable;
  logic            clear;
  logic [N-1:0]    event_in;
  logic [IDXW-1:0] idx;
  logic            valid;
  logic            ready;
  logic [N-1:0]    pending;
  logic            drop;
  logic [7:0]      drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int mon_exp;

  event_encoder16 dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .enable_i   (enable),
    .clear_i    (clear),
    .event_i    (event_in),
    .idx_o      (idx),
    .valid_o    (valid),
    .ready_i    (ready),
    .pending_o  (pending),
    .drop_o     (drop),
    .drop_cnt_o (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] ev);
    event_in = ev;
    step();
    event_in = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
  endtask

  // Monitor: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn && valid && ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL handshake: unexpected idx %0d with empty scoreboard", idx);
      end else begin
        mon_exp = exp_q.pop_front();
        if (idx !== IDXW'(mon_exp)) begin
          n_fail++;
          $display("FAIL handshake: got idx %0d expected %0d", idx, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rstn     = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    event_in = '0;
    ready    = 1'b0;
    #3;
    check("rst_idx", 32'(idx), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_cnt", 32'(drop_cnt), 0);
    step();
    step();
    rstn = 1'b1;
    step();

    // Single event
    ready = 1'b1;
    pulse(16'h0010);
    check("single_pend", 32'(pending), 32'h0010);
    check("single_nvalid", 32'(valid), 0);
    exp_q.push_back(4);
    step();
    check("single_valid", 32'(valid), 1);
    check("single_idx", 32'(idx), 4);
    step();
    check("single_done_valid", 32'(valid), 0);
    check("single_done_pend", 32'(pending), 0);
    ready = 1'b0;

    // Round robin with wrap and re-arm of bit 0
    do_reset();
    pulse(16'h8003);
    step();
    check("rr_first", 32'(idx), 0);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(15);
    exp_q.push_back(0);
    ready    = 1'b1;
    event_in = 16'h0001;
    step();
    event_in = '0;
    check("rr_rearm_nodrop", 32'(drop), 0);
    check("rr_rearm_pend", 32'(pending), 32'h8003);
    check("rr_second", 32'(idx), 1);
    step();
    step();
    step();
    check("rr_done_valid", 32'(valid), 0);
    check("rr_done_pend", 32'(pending), 0);
    ready = 1'b0;

    // Backpressure
    do_reset();
    pulse(16'h0006);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(valid), 1);
      check("bp_idx", 32'(idx), 1);
      step();
    end
    exp_q.push_back(1);
    exp_q.push_back(2);
    ready = 1'b1;
    step();
    check("bp_next", 32'(idx), 2);
    step();
    check("bp_done_valid", 32'(valid), 0);
    ready = 1'b0;

    // Drop versus re-arm
    do_reset();
    pulse(16'h0009);
    step();
    pulse(16'h0008);
    check("drop_pulse", 32'(drop), 1);
    check("drop_cnt1", 32'(drop_cnt), 1);
    step();
    check("drop_clear", 32'(drop), 0);
    check("drop_cnt_hold", 32'(drop_cnt), 1);
    exp_q.push_back(0);
    exp_q.push_back(3);
    exp_q.push_back(3);
    ready = 1'b1;
    step();
    event_in = 16'h0008;
    step();
    event_in = '0;
    ready    = 1'b0;
    check("rearm_nodrop", 32'(drop), 0);
    check("rearm_cnt", 32'(drop_cnt), 1);
    check("rearm_pend", 32'(pending), 32'h0008);
    step();
    check("rearm_valid", 32'(valid), 1);
    check("rearm_idx", 32'(idx), 3);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("rearm_done", 32'(valid), 0);

    // Drop counter saturation
    pulse(16'h0020);
    step();
    check("sat_idx", 32'(idx), 5);
    event_in = 16'h0020;
    repeat (300) step();
    check("sat_drop", 32'(drop), 1);
    check("sat_cnt", 32'(drop_cnt), 255);
    event_in = '0;
    step();
    check("sat_drop_end", 32'(drop), 0);
    check("sat_cnt_hold", 32'(drop_cnt), 255);

    // enable low ignores events
    enable = 1'b0;
    pulse(16'hFFFF);
    enable = 1'b1;
    check("en_pend", 32'(pending), 32'h0020);
    check("en_nodrop", 32'(drop), 0);
    check("en_idx", 32'(idx), 5);

    // clear with event and accept
    exp_q.push_back(5);
    clear    = 1'b1;
    event_in = 16'h0001;
    ready    = 1'b1;
    step();
    clear    = 1'b0;
    event_in = '0;
    ready    = 1'b0;
    check("clr_pend", 32'(pending), 0);
    check("clr_valid", 32'(valid), 0);
    check("clr_cnt", 32'(drop_cnt), 0);
    check("clr_drop", 32'(drop), 0);
    check("clr_idx", 32'(idx), 0);
    step();
    check("clr_after_valid", 32'(valid), 0);

    // Async reset mid-handshake
    pulse(16'h0040);
    step();
    check("ar_idx", 32'(idx), 6);
    pulse(16'h0040);
    check("ar_cnt_pre", 32'(drop_cnt), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_valid", 32'(valid), 0);
    check("ar_idx0", 32'(idx), 0);
    check("ar_pend", 32'(pending), 0);
    check("ar_drop", 32'(drop), 0);
    check("ar_cnt", 32'(drop_cnt), 0);
    step();
    rstn = 1'b1;
    pulse(16'h0100);
    step();
    check("ar_post_valid", 32'(valid), 1);
    check("ar_post_idx", 32'(idx), 8);
    exp_q.push_back(8);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("ar_post_done", 32'(valid), 0);

    repeat (3) step();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/event_encoder16.md
# event_encoder16

Sequential 16-to-4 event encoder. It captures single-cycle event pulses from 16 sources into a sticky pending register. Pending events are serialized as 4-bit indices over a valid/ready handshake, in round-robin order. It is the encoding counterpart of the 4-to-16 one-hot decoder used in the PMU event/interrupt path: the decoder fans an index out to 16 lines, and this block folds 16 lines back into an index stream for the interrupt or trace consumer.

## Interface
- N, 16, number of event sources; only 16 is supported.
- IDXW, 4, index width, equal to $clog2(N).

Ports:
- clk_i  input  1  single clock, rising edge.
- rstn_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  when low, new events are ignored; already pending events still drain.
- clear_i  input  1  synchronous flush of all state.
- event_i  input  N  event pulses; each bit is sampled every cycle.
- idx_o  output  IDXW  index of the presented event.
- valid_o  output  1  idx_o is valid.
- ready_i  input  1  consumer accepts idx_o.
- pending_o  output  N  current pending register.
- drop_o  output  1  one-cycle pulse when at least one event was lost this cycle.
- drop_cnt_o  output  8  saturating count of lost-event cycles.

## Operation
- Accept condition: accept = valid_o & ready_i. ack_mask = accept ? onehot(idx_o) : 0.
- Pending update: pending_next = (pending_q & ~ack_mask) | (event_i & {N{enable_i}}).
  - An event on the bit being acked in the same cycle re-sets that bit. It is not a drop.
- Drop: a drop occurs when enable_i is high, event_i[k] is set, pending_q[k] is set, and bit k is not acked this cycle.
  - drop_o pulses for one cycle. drop_cnt_o increments by 1 per such cycle, regardless of how many bits dropped, and saturates at 255.
- Output register: the encoder selects from cand = pending_q & ~ack_mask. Raw event_i is never used for selection.
  - Load condition: !valid_o | accept.
  - On load: if cand is non-zero, idx_o takes the round-robin winner and valid_o goes high. Otherwise valid_o goes low and idx_o holds its value.
  - While valid_o is high and ready_i is low, idx_o and valid_o are held stable.
  - While a bit is presented it stays set in pending_q and is never reselected.
- Round robin:
  - ptr_q is a 4-bit pointer. The winner is the first set bit of cand, searching upward from ptr_q with modulo-16 wrap.
  - On every accept, ptr_q = idx_o + 1 mod 16. ptr_q does not change on load without accept.
- clear_i: on the next edge, pending_q, valid_o, idx_o, ptr_q and drop_cnt_o become 0.
  - clear_i has priority over events, accepts and drops in the same cycle. drop_o is 0 that cycle.
- Reset (rstn_i low): pending_o=0, valid_o=0, idx_o=0, ptr_q=0, drop_o=0, drop_cnt_o=0. Reset acts immediately and asynchronously, including mid-handshake; the in-flight index is discarded.

## Timing
- Latency: event at edge t sets pending at t+1; valid_o is high after edge t+2 if the output register is idle.
- Throughput: one index per cycle with ready_i held high, while pending holds other bits.
- An event sampled in an accept cycle becomes eligible for selection from the next cycle.
- idx_o, valid_o, drop_o and drop_cnt_o are all registered. There is no combinational path from event_i or ready_i to any output.
- pending_o reflects pending_q, which is registered.

## Structure
- Package event_enc_pkg holds the constants N=16 and IDXW=4 and a onehot16 function (index to 16-bit mask).
- Sub-module rr_prio_enc16 is purely combinational.
  - Inputs: cand[15:0], ptr[3:0].
  - Outputs: idx[3:0], found.
  - Implement it by rotate-right by ptr, fixed priority LSB-first, then add ptr mod 16.
- The top level holds pending_q, the output register, ptr_q and the drop counter.

## Test plan
- Single event: reset, event_i=16'h0010 for one cycle, ready_i=1 → valid_o high two edges later with idx_o=4, accepted once. pending_o then reads 0 and valid_o drops.
- Round robin with wrap: preload pending=16'h8003, ptr_q=0, ready_i=1 → idx_o sequence is 0, 1, 15 on consecutive cycles. Inject bit 0 again after its ack → bit 0 is granted after 15, not before 1.
- Backpressure: pending=16'h0006, ready_i=0 for 5 cycles → idx_o=1 and valid_o=1 stable throughout. Raise ready_i → 1 then 2 accepted back-to-back.
- Drop vs. re-arm:
  - event_i[3] pulsed while bit 3 is pending and unpresented → drop_o=1, drop_cnt_o=1.
  - event_i[3] pulsed in the same cycle bit 3 is accepted → no drop; bit 3 is presented again.
  - Force 300 drop cycles → drop_cnt_o=255.
- enable_i and clear_i:
  - enable_i=0 with event_i=16'hFFFF → pending unchanged.
  - clear_i together with event_i=16'h0001 and an accept → next cycle pending_o=0, valid_o=0, drop_cnt_o=0.
- Async reset mid-handshake: rstn_i low while valid_o=1 and ready_i=0 → all outputs 0 immediately, without waiting for a clock edge. Release reset, pulse event_i=16'h0100 → idx_o=8.
